// File: rtl/frame_buffer_pkg.sv
// Shared types and default geometry for the ping-pong frame store.
//   pixel_t    : one pixel at the default RGB888 width
//   wr_state_e : write-side sequencing states
package frame_buffer_pkg;

  localparam int DEF_WIDTH      = 320;
  localparam int DEF_HEIGHT     = 240;
  localparam int DEF_PIXEL_BITS = 24;

  typedef logic [DEF_PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/frame_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Contents are never reset. A read and a write to the same word in the same
// cycle never happen here (the two ports always address different banks),
// so no read-during-write bypass is built.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every edge
//   rd_data  : registered read data (1-cycle latency)
module frame_buffer_sdp_ram #(
  parameter int P_ADDR_BITS = 18,
  parameter int P_DATA_BITS = 24,
  parameter int P_DEPTH     = 1 << P_ADDR_BITS
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [P_ADDR_BITS-1:0] wr_addr,
  input  logic [P_DATA_BITS-1:0] wr_data,
  input  logic [P_ADDR_BITS-1:0] rd_addr,
  output logic [P_DATA_BITS-1:0] rd_data
);

  (* ramstyle = "M10K, no_rw_check" *)
  logic [P_DATA_BITS-1:0] mem [P_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store between the camera pixel stream and scan-out.
// The display reads the active bank; incoming frames fill the other bank.
// Banks swap only at a display vsync and only once a full frame is waiting.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a frame start; stray pixels are dropped silently
// FILL  | writing pixels at the write counter
// DONE  | full frame held in the write bank, waiting for vsync swap
//
// Ports:
//   piul1Clock       : clock for both sides
//   piul1Reset_n     : async active-low reset
//   piul1FrameStart  : marks first pixel of an incoming frame
//   piul1PixelValid  : pixel write strobe
//   piulPixelData    : pixel to store
//   piul1ReadVsync   : display vertical-blank pulse (swap point)
//   piulReadAddress  : scan-out address
//   poulReadData     : scan-out pixel, 1-cycle latency, zero when out of range
//   poul1FrameReady  : complete frame waiting for swap
//   poul1ActiveBank  : bank being displayed
//   poul1Overflow    : pulse, pixel dropped while a frame is waiting
//   poul1ShortFrame  : pulse, frame restarted before completion
module frame_buffer_pingpong
  import frame_buffer_pkg::*;
#(
  parameter  int P_WIDTH      = DEF_WIDTH,
  parameter  int P_HEIGHT     = DEF_HEIGHT,
  parameter  int P_PIXEL_BITS = DEF_PIXEL_BITS,
  localparam int P_DEPTH      = P_WIDTH * P_HEIGHT,
  localparam int P_ADDR_BITS  = $clog2(P_DEPTH)
) (
  input  logic                    piul1Clock,
  input  logic                    piul1Reset_n,
  input  logic                    piul1FrameStart,
  input  logic                    piul1PixelValid,
  input  logic [P_PIXEL_BITS-1:0] piulPixelData,
  input  logic                    piul1ReadVsync,
  input  logic [P_ADDR_BITS-1:0]  piulReadAddress,
  output logic [P_PIXEL_BITS-1:0] poulReadData,
  output logic                    poul1FrameReady,
  output logic                    poul1ActiveBank,
  output logic                    poul1Overflow,
  output logic                    poul1ShortFrame
);

  localparam logic [P_ADDR_BITS-1:0] LAST_ADDR = P_ADDR_BITS'(P_DEPTH - 1);
  // One extra bit so the compare also works when P_DEPTH is a power of two.
  localparam logic [P_ADDR_BITS:0]   DEPTH_EXT = (P_ADDR_BITS + 1)'(P_DEPTH);
  // Bank select is the address MSB, so each bank occupies a power-of-two span.
  localparam int RAM_DEPTH = 1 << (P_ADDR_BITS + 1);

  wr_state_e state, state_next;

  logic [P_ADDR_BITS-1:0]  wr_cnt, wr_cnt_next, wr_addr;
  logic                    wr_en, wr_last, swap;
  logic                    overflow_d, short_d;
  logic                    active_bank, shown_valid, rd_mask;
  logic [P_PIXEL_BITS-1:0] ram_q;

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (piul1FrameStart) state_next = wr_last ? DONE : FILL;
      FILL:    if (wr_last)         state_next = DONE;
      DONE:    if (piul1ReadVsync)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  // A frame start always forces the write address to 0 so a pixel arriving
  // with it lands at the top of the frame.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = wr_cnt;
    overflow_d = 1'b0;
    short_d    = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (piul1FrameStart) begin
          wr_en   = piul1PixelValid;
          wr_addr = '0;
        end
      end
      FILL: begin
        wr_en   = piul1PixelValid;
        short_d = piul1FrameStart;
        if (piul1FrameStart) wr_addr = '0;
      end
      DONE: begin
        overflow_d = piul1PixelValid;
        swap       = piul1ReadVsync;
      end
      default: ;
    endcase
  end

  assign wr_last = wr_en && (wr_addr == LAST_ADDR);

  // Counter wraps to 0 on the last pixel so it is already clear for the
  // next frame; it never exceeds LAST_ADDR.
  always_comb begin
    wr_cnt_next = wr_cnt;
    if (wr_en) begin
      wr_cnt_next = wr_last ? '0 : wr_addr + 1'b1;
    end else if ((state == FILL) && piul1FrameStart) begin
      wr_cnt_next = '0;
    end
  end

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      wr_cnt          <= '0;
      active_bank     <= 1'b0;
      shown_valid     <= 1'b0;
      poul1FrameReady <= 1'b0;
      poul1Overflow   <= 1'b0;
      poul1ShortFrame <= 1'b0;
    end else begin
      wr_cnt          <= wr_cnt_next;
      poul1FrameReady <= (state_next == DONE);
      poul1Overflow   <= overflow_d;
      poul1ShortFrame <= short_d;
      if (swap) begin
        active_bank <= ~active_bank;
        shown_valid <= 1'b1;
      end
    end
  end

  // Read side. The mask is sampled at the same edge as the RAM address, so a
  // read at the swap edge still uses the old bank and old validity. Until the
  // first swap after reset the displayed bank holds nothing written, so it is
  // shown as black rather than as uninitialised RAM.
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      rd_mask <= 1'b1;
    end else begin
      rd_mask <= !shown_valid || ({1'b0, piulReadAddress} >= DEPTH_EXT);
    end
  end

  frame_buffer_sdp_ram #(
    .P_ADDR_BITS (P_ADDR_BITS + 1),
    .P_DATA_BITS (P_PIXEL_BITS),
    .P_DEPTH     (RAM_DEPTH)
  ) u_ram (
    .clk     (piul1Clock),
    .wr_en   (wr_en),
    .wr_addr ({~active_bank, wr_addr}),
    .wr_data (piulPixelData),
    .rd_addr ({active_bank, piulReadAddress}),
    .rd_data (ram_q)
  );

  assign poulReadData    = rd_mask ? '0 : ram_q;
  assign poul1ActiveBank = active_bank;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for frame_buffer_pingpong on a reduced 5x3 geometry so that
// full frames stay short; address 15 is the only out-of-range read address.
module tb_frame_buffer_pingpong;

  localparam int W     = 5;
  localparam int H     = 3;
  localparam int DEPTH = W * H;
  localparam int AB    = $clog2(DEPTH);
  localparam int PB    = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fs, pv, vs;
  logic [PB-1:0] pdata;
  logic [AB-1:0] raddr;
  logic [PB-1:0] rd;
  logic          ready, bank, ovf, shrt;

  int n_checks = 0;
  int n_fail   = 0;

  frame_buffer_pingpong #(
    .P_WIDTH      (W),
    .P_HEIGHT     (H),
    .P_PIXEL_BITS (PB)
  ) dut (
    .piul1Clock      (clk),
    .piul1Reset_n    (rst_n),
    .piul1FrameStart (fs),
    .piul1PixelValid (pv),
    .piulPixelData   (pdata),
    .piul1ReadVsync  (vs),
    .piulReadAddress (raddr),
    .poulReadData    (rd),
    .poul1FrameReady (ready),
    .poul1ActiveBank (bank),
    .poul1Overflow   (ovf),
    .poul1ShortFrame (shrt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          fs;
    logic          pv;
    logic [PB-1:0] data;
    logic          vs;
    logic [AB-1:0] addr;
    logic          ready;
    logic          bank;
    logic          ovf;
    logic          shrt;
    logic [PB-1:0] rd;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic f, input logic p, input logic [PB-1:0] d,
                              input logic v, input logic [AB-1:0] a,
                              input logic e_ready, input logic e_bank,
                              input logic e_ovf, input logic e_shrt,
                              input logic [PB-1:0] e_rd);
    vec_t r;
    r.fs = f; r.pv = p; r.data = d; r.vs = v; r.addr = a;
    r.ready = e_ready; r.bank = e_bank; r.ovf = e_ovf; r.shrt = e_shrt; r.rd = e_rd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic cyc(input logic f, input logic p, input logic [PB-1:0] d,
                     input logic v, input logic [AB-1:0] a);
    fs = f; pv = p; pdata = d; vs = v; raddr = a;
    @(posedge clk);
    #1;
  endtask

  int ovf_cnt;
  int shrt_cnt;
  logic [AB-1:0] rd_list [4];
  logic [PB-1:0] inv;

  initial begin
    // Frame B: data = ~address written while frame A (data = address) is shown.
    tbl[0] = mk(1, 1, 24'hFFFFFF, 0, 4'd3, 0, 1, 0, 0, 24'd3);
    for (int i = 1; i < DEPTH; i++) begin
      inv = 24'hFFFFFF ^ PB'(i);
      // Last pixel coincides with vsync: still FILL, so no swap.
      tbl[i] = mk(0, 1, inv, (i == DEPTH - 1), AB'(i), (i == DEPTH - 1), 1, 0, 0, PB'(i));
    end
    tbl[15] = mk(0, 1, 24'h123456, 0, 4'd15, 1, 1, 1, 0, 24'h0);     // overflow, OOB read
    tbl[16] = mk(0, 0, 24'h0,      0, 4'd5,  1, 1, 0, 0, 24'd5);
    tbl[17] = mk(1, 0, 24'h0,      0, 4'd5,  1, 1, 0, 0, 24'd5);     // start ignored in DONE
    tbl[18] = mk(0, 0, 24'h0,      1, 4'd5,  0, 0, 0, 0, 24'd5);     // swap, old bank read
    tbl[19] = mk(0, 0, 24'h0,      0, 4'd5,  0, 0, 0, 0, 24'hFFFFFA);
    tbl[20] = mk(0, 0, 24'h0,      0, 4'd14, 0, 0, 0, 0, 24'hFFFFF1);
    tbl[21] = mk(0, 0, 24'h0,      1, 4'd0,  0, 0, 0, 0, 24'hFFFFFF); // vsync in IDLE
    tbl[22] = mk(0, 1, 24'h000777, 0, 4'd0,  0, 0, 0, 0, 24'hFFFFFF); // pixel in IDLE

    rd_list[0] = 4'd0; rd_list[1] = 4'd4; rd_list[2] = 4'd5; rd_list[3] = 4'd14;

    fs = 0; pv = 0; vs = 0; pdata = '0; raddr = '0;
    rst_n = 1'b0;

    // ---- reset state ----
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("reset_rd",    rd,    0);
    check("reset_bank",  bank,  0);
    check("reset_ready", ready, 0);
    check("reset_ovf",   ovf,   0);
    check("reset_short", shrt,  0);
    rst_n = 1'b1;

    // ---- frame A: data = address ----
    cyc(1, 1, 24'd0, 0, 0);
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 1, PB'(i), 0, 0);
      if (i == DEPTH - 2) check("a_ready_before_last", ready, 0);
    end
    check("a_ready_after_last", ready, 1);
    check("a_bank_before_swap", bank,  0);
    check("a_rd_before_swap",   rd,    0);
    cyc(0, 0, 0, 1, 0);
    check("a_bank_swap",  bank,  1);
    check("a_ready_swap", ready, 0);
    cyc(0, 0, 0, 0, 4'd9);
    check("a_rd_9", rd, 24'd9);
    cyc(0, 0, 0, 0, 4'd15);
    check("a_rd_oob", rd, 0);

    // ---- table: frame B, last-pixel vsync, overflow, swap ordering ----
    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].fs, tbl[i].pv, tbl[i].data, tbl[i].vs, tbl[i].addr);
      check($sformatf("vec%0d_ready", i), ready, tbl[i].ready);
      check($sformatf("vec%0d_bank",  i), bank,  tbl[i].bank);
      check($sformatf("vec%0d_ovf",   i), ovf,   tbl[i].ovf);
      check($sformatf("vec%0d_short", i), shrt,  tbl[i].shrt);
      check($sformatf("vec%0d_rd",    i), rd,    tbl[i].rd);
    end

    // ---- short frame: restart after 5 pixels ----
    shrt_cnt = 0;
    cyc(1, 1, 24'h100, 0, 0);
    shrt_cnt += int'(shrt);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 1, 24'h100 + PB'(i), 0, 0);
      shrt_cnt += int'(shrt);
    end
    cyc(1, 1, 24'h200, 0, 0);
    check("short_pulse", shrt, 1);
    shrt_cnt += int'(shrt);
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 1, 24'h200 + PB'(i), 0, 0);
      shrt_cnt += int'(shrt);
      if (i == DEPTH - 2) check("short_ready_before_last", ready, 0);
    end
    check("short_pulse_count",      shrt_cnt, 1);
    check("short_ready_after_last", ready,    1);

    // ---- overflow: 5 extra pixels while DONE ----
    ovf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 24'hDEAD, 0, 0);
      ovf_cnt += int'(ovf);
    end
    cyc(0, 0, 0, 0, 0);
    ovf_cnt += int'(ovf);
    check("ovf_count",   ovf_cnt, 5);
    check("ovf_cleared", ovf,     0);
    cyc(0, 0, 0, 1, 0);
    check("short_swap_bank", bank, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, rd_list[k]);
      check($sformatf("short_rd_%0d", rd_list[k]), rd, 24'h200 + PB'(rd_list[k]));
    end

    // ---- reset in the middle of a fill ----
    cyc(1, 1, 24'h300, 0, 0);
    cyc(0, 1, 24'h301, 0, 0);
    cyc(0, 1, 24'h302, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_bank",  bank,  0);
    check("midrst_ready", ready, 0);
    check("midrst_rd",    rd,    0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 24'h400 + PB'(i), 0, 0);
    check("midrst_no_start_ready", ready, 0);
    cyc(0, 0, 0, 1, 0);
    check("midrst_idle_vsync_bank", bank, 0);
    cyc(1, 1, 24'h500, 0, 0);
    for (int i = 1; i < DEPTH; i++) cyc(0, 1, 24'h500 + PB'(i), 0, 0);
    check("midrst_frame_ready", ready, 1);
    cyc(0, 0, 0, 1, 0);
    check("midrst_swap_bank", bank, 1);
    cyc(0, 0, 0, 0, 4'd0);
    check("midrst_rd_0", rd, 24'h500);
    cyc(0, 0, 0, 0, 4'd14);
    check("midrst_rd_14", rd, 24'h50E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
